// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run/halt/watchdog controller.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } run_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_HALT    = 2'd1,
    CAUSE_STALL   = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } halt_cause_e;

  // Opcode 111 with operand 0 is the core's halt instruction.
  localparam logic [8:0] HALT_WORD_DEFAULT = 9'h1C0;

endpackage

// File: rtl/stall_detect.sv
// PC stall detector: flags when the PC has stayed unchanged for
// STALL_CYCLES consecutive enabled cycles (including the current one).
module stall_detect
  import run_ctrl_pkg::*;
#(
  parameter int PC_W         = 7,
  parameter int STALL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            en,
  input  logic [PC_W-1:0] pc,
  output logic            stalled
);

  localparam int              SC_W    = $clog2(STALL_CYCLES + 1);
  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STALL_CYCLES);
  localparam logic [SC_W-1:0] SC_TRIP = SC_W'(STALL_CYCLES - 1);

  logic [PC_W-1:0] prev_pc_q;
  logic            valid_q;
  logic [SC_W-1:0] cnt_q;
  logic [SC_W-1:0] cnt_d;
  logic            same_pc;

  function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
    return (v >= SC_MAX) ? SC_MAX : v + SC_W'(1);
  endfunction

  // prev_pc is meaningless on the first enabled cycle, so valid_q gates it.
  assign same_pc = valid_q && (pc == prev_pc_q);
  assign cnt_d   = same_pc ? sat_inc(cnt_q) : '0;
  // The current cycle counts toward the run, so trip one below the limit.
  assign stalled = en && same_pc && (cnt_q >= SC_TRIP);

  // Control state: first-cycle valid flag and consecutive-stall counter.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (en) begin
      valid_q <= 1'b1;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the PC of every enabled cycle for next cycle's comparison.
  always_ff @(posedge clk) begin
    if (en) prev_pc_q <= pc;
  end

endmodule

// File: rtl/run_ctrl.sv
// Run/halt/watchdog controller: turns a start request into a core reset
// window and a run window, then ends the run on halt, PC stall or timeout.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int                   PC_W         = 7,
  parameter int                   INSTR_W      = 9,
  parameter int                   CNT_W        = 10,
  parameter int                   MAX_CYCLES   = 1000,
  parameter int                   STALL_CYCLES = 2,
  parameter logic [INSTR_W-1:0]   HALT_WORD    = INSTR_W'(HALT_WORD_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instruction,
  output logic               core_reset,
  output logic               run,
  output logic               done,
  output logic [1:0]         halt_cause,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  run_state_e       state_q, state_d;
  halt_cause_e      cause_q, cause_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             core_reset_q, run_q, done_q;
  logic             stall_clear, stall_en, stalled;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
  endfunction

  // Stall tracking restarts while armed and only observes RUN cycles.
  assign stall_clear = (state_q == ST_ARMED);
  assign stall_en    = (state_q == ST_RUN);

  stall_detect #(
    .PC_W         (PC_W),
    .STALL_CYCLES (STALL_CYCLES)
  ) u_stall (
    .clk     (clk),
    .reset   (reset),
    .clear   (stall_clear),
    .en      (stall_en),
    .pc      (pc),
    .stalled (stalled)
  );

  // Next-state logic; RUN exits are checked in priority order.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!start) state_d = ST_RUN;
      end
      ST_RUN: begin
        count_d = sat_inc(count_q);
        if (start) begin
          state_d = ST_ARMED;
        end else if (instruction == HALT_WORD) begin
          state_d = ST_DONE;
          cause_d = CAUSE_HALT;
        end else if (stalled) begin
          state_d = ST_DONE;
          cause_d = CAUSE_STALL;
        end else if (count_q == LAST_CYCLE) begin
          state_d = ST_TIMEOUT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_DONE, ST_TIMEOUT: begin
        if (start) state_d = ST_ARMED;
      end
      default: state_d = ST_IDLE;
    endcase
    // Every entry into ARMED starts a fresh run record.
    if (state_d == ST_ARMED && state_q != ST_ARMED) begin
      count_d = '0;
      cause_d = CAUSE_NONE;
    end
  end

  // State, counter and outputs, all registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cause_q      <= CAUSE_NONE;
      count_q      <= '0;
      core_reset_q <= 1'b1;
      run_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      count_q      <= count_d;
      core_reset_q <= (state_d == ST_IDLE) || (state_d == ST_ARMED);
      run_q        <= (state_d == ST_RUN);
      done_q       <= (state_d == ST_DONE) || (state_d == ST_TIMEOUT);
    end
  end

  assign core_reset  = core_reset_q;
  assign run         = run_q;
  assign done        = done_q;
  assign halt_cause  = cause_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: halt, stall, timeout, priority, restart, abort.
module tb_run_ctrl;

  localparam int PC_W    = 7;
  localparam int INSTR_W = 9;
  localparam int CNT_W   = 10;
  localparam int MAXC    = 20;
  localparam logic [INSTR_W-1:0] HALT = 9'h1C0;
  localparam logic [INSTR_W-1:0] NOP  = 9'h001;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instruction;
  logic               core_reset, run, done;
  logic [1:0]         halt_cause;
  logic [CNT_W-1:0]   cycle_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  run_ctrl #(
    .PC_W         (PC_W),
    .INSTR_W      (INSTR_W),
    .CNT_W        (CNT_W),
    .MAX_CYCLES   (MAXC),
    .STALL_CYCLES (2),
    .HALT_WORD    (HALT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pc          (pc),
    .instruction (instruction),
    .core_reset  (core_reset),
    .run         (run),
    .done        (done),
    .halt_cause  (halt_cause),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From IDLE/DONE/TIMEOUT: raise start, check the armed view, drop it.
  task automatic arm_and_go(input int hold);
    start = 1'b1;
    tick();
    chk("armed_core_rst", 32'(core_reset), 1);
    chk("armed_run", 32'(run), 0);
    chk("armed_done", 32'(done), 0);
    chk("armed_cnt", 32'(cycle_count), 0);
    chk("armed_cause", 32'(halt_cause), 0);
    for (int i = 1; i < hold; i++) tick();
    start = 1'b0;
    tick();
  endtask

  // Drive one program from RUN cycle 1 until done rises (bounded).
  task automatic run_until_done(input int halt_at, input int stall_from, output int done_cyc);
    bit fin;
    fin = 1'b0;
    done_cyc = 0;
    for (int c = 1; c <= 40 && !fin; c++) begin
      chk("run_hi", 32'(run), 1);
      chk("run_core_rst", 32'(core_reset), 0);
      chk("run_cnt", 32'(cycle_count), c - 1);
      pc = (stall_from > 0 && c >= stall_from) ? PC_W'(12) : PC_W'((c - 1) % 8);
      instruction = (c == halt_at) ? HALT : NOP;
      tick();
      if (done) begin
        fin = 1'b1;
        done_cyc = c;
      end
    end
    if (!fin) chk("done_never_rose", 0, 1);
    instruction = NOP;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pc = '0;
    instruction = NOP;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_core_rst", 32'(core_reset), 1);
    chk("rst_run", 32'(run), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cause", 32'(halt_cause), 0);
    chk("rst_cnt", 32'(cycle_count), 0);

    // Halt at PC 5 on RUN cycle 6.
    arm_and_go(3);
    run_until_done(6, 0, cyc);
    chk("halt_cyc", cyc, 6);
    chk("halt_cause", 32'(halt_cause), 1);
    chk("halt_cnt", 32'(cycle_count), 6);
    chk("halt_run", 32'(run), 0);
    chk("halt_core_rst", 32'(core_reset), 0);
    tick();
    chk("halt_hold_done", 32'(done), 1);
    chk("halt_hold_cnt", 32'(cycle_count), 6);

    // Self-branch at PC 12 from RUN cycle 4.
    arm_and_go(1);
    run_until_done(0, 4, cyc);
    chk("stall_cyc", cyc, 6);
    chk("stall_cause", 32'(halt_cause), 2);
    chk("stall_cnt", 32'(cycle_count), 6);

    // Changing PC, never halts: watchdog fires.
    arm_and_go(1);
    run_until_done(0, 0, cyc);
    chk("to_cyc", cyc, MAXC);
    chk("to_cause", 32'(halt_cause), 3);
    chk("to_cnt", 32'(cycle_count), MAXC);
    chk("to_run", 32'(run), 0);
    tick();
    tick();
    chk("to_hold_done", 32'(done), 1);
    chk("to_hold_cnt", 32'(cycle_count), MAXC);

    // Halt fetched on the timeout cycle.
    arm_and_go(1);
    run_until_done(MAXC, 0, cyc);
    chk("ht_cyc", cyc, MAXC);
    chk("ht_cause", 32'(halt_cause), 1);
    chk("ht_cnt", 32'(cycle_count), MAXC);

    // Start and halt together on RUN cycle 3: restart wins.
    arm_and_go(1);
    for (int c = 1; c <= 3; c++) begin
      pc = PC_W'(c - 1);
      instruction = (c == 3) ? HALT : NOP;
      start = (c == 3);
      tick();
    end
    instruction = NOP;
    chk("sh_core_rst", 32'(core_reset), 1);
    chk("sh_run", 32'(run), 0);
    chk("sh_done", 32'(done), 0);
    chk("sh_cnt", 32'(cycle_count), 0);
    chk("sh_cause", 32'(halt_cause), 0);

    // Second run from there, aborted by reset on RUN cycle 7.
    start = 1'b0;
    tick();
    for (int c = 1; c <= 7; c++) begin
      chk("ab_run", 32'(run), 1);
      pc = PC_W'(c - 1);
      reset = (c == 7);
      tick();
    end
    reset = 1'b0;
    chk("ab_core_rst", 32'(core_reset), 1);
    chk("ab_run_lo", 32'(run), 0);
    chk("ab_cnt", 32'(cycle_count), 0);
    chk("ab_done", 32'(done), 0);

    // Start held high keeps the core in reset.
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_core_rst", 32'(core_reset), 1);
      chk("hold_run", 32'(run), 0);
    end
    start = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
